// File: rtl/ca_rule_sequencer.sv
// ca_rule_sequencer: loads a seed into the bit-changer register and evolves it for a programmed
// number of elementary-CA generations. Define CA_NULL_BOUNDARY_EN for zero boundary cells instead of wrap-around.
module ca_rule_sequencer #(
  parameter int         N    = 25,
  parameter logic [7:0] RULE = 8'd90
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [N-1:0]         seed,
  input  logic [7:0]           gens,
  input  logic [N-1:0]         cur,
  output logic                 ld,
  output logic [N-1:0]         ld_data,
  output logic                 clr,
  output logic                 en,
  output logic [$clog2(N)-1:0] bitSelect,
  output logic                 bitChange,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           gen_cnt
);

  localparam int             IW       = $clog2(N);
  localparam logic [IW-1:0]  IDX_LAST = IW'(N - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_SNAP = 3'd2;
  localparam logic [2:0] S_SCAN = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [N-1:0]  seed_q, seed_d;
  logic [N-1:0]  snap_q, snap_d;
  logic [7:0]    gens_q, gens_d;
  logic [7:0]    gen_cnt_q, gen_cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          clr_q, clr_d;

  logic [7:0]    gen_cnt_inc;
  logic [IW-1:0] idx_l, idx_r;
  logic [2:0]    pattern;

  always_comb begin
    // NOTE: every next-state signal takes its held value first, so no branch can infer a latch.
    state_d     = state_q;
    seed_d      = seed_q;
    snap_d      = snap_q;
    gens_d      = gens_q;
    gen_cnt_d   = gen_cnt_q;
    idx_d       = idx_q;
    clr_d       = 1'b0;
    gen_cnt_inc = gen_cnt_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          seed_d    = seed;
          gens_d    = gens;
          gen_cnt_d = 8'd0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          clr_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = (gens_q == 8'd0) ? S_DONE : S_SNAP;
        end
      end
      S_SNAP: begin
        if (abort) begin
          clr_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          // The register settled on the previous edge, so cur is this generation's start word.
          snap_d  = cur;
          idx_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (abort) begin
          clr_d   = 1'b1;
          idx_d   = '0;
          state_d = S_IDLE;
        end else if (idx_q == IDX_LAST) begin
          idx_d     = '0;
          gen_cnt_d = gen_cnt_inc;
          state_d   = (gen_cnt_inc == gens_q) ? S_DONE : S_SNAP;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Explicit wrap keeps every neighbour index inside 0..N-1 even when N is not a power of two.
  always_comb begin
    idx_l      = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    idx_r      = (idx_q == '0) ? IDX_LAST : idx_q - IW'(1);
    pattern[1] = snap_q[idx_q];
`ifdef CA_NULL_BOUNDARY_EN
    pattern[2] = (idx_q == IDX_LAST) ? 1'b0 : snap_q[idx_l];
    pattern[0] = (idx_q == '0) ? 1'b0 : snap_q[idx_r];
`else
    pattern[2] = snap_q[idx_l];
    pattern[0] = snap_q[idx_r];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      seed_q    <= '0;
      snap_q    <= '0;
      gens_q    <= 8'd0;
      gen_cnt_q <= 8'd0;
      idx_q     <= '0;
      clr_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q   <= state_d;
      seed_q    <= seed_d;
      snap_q    <= snap_d;
      gens_q    <= gens_d;
      gen_cnt_q <= gen_cnt_d;
      idx_q     <= idx_d;
      clr_q     <= clr_d;
    end
  end

  assign ld        = (state_q == S_LOAD);
  assign ld_data   = seed_q;
  assign clr       = clr_q;
  assign en        = (state_q == S_SCAN);
  assign bitSelect = idx_q;
  assign bitChange = en & RULE[pattern];
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign gen_cnt   = gen_cnt_q;

endmodule

// File: tb/tb_ca_rule_sequencer.sv
// Bench for ca_rule_sequencer: RULE=90 and RULE=204 instances share stimulus, each with its own
// bit-changer model; a generation-level model predicts every output cycle by cycle.
module tb_ca_rule_sequencer;

  localparam int N  = 25;
  localparam int IW = $clog2(N);

`ifdef CA_NULL_BOUNDARY_EN
  localparam logic [N-1:0] EXP_G1 = 25'h0000002;
  localparam logic [N-1:0] EXP_G2 = 25'h0000005;
`else
  localparam logic [N-1:0] EXP_G1 = 25'h1000002;
  localparam logic [N-1:0] EXP_G2 = 25'h0800004;
`endif

  typedef struct packed {
    bit                  ld;
    bit                  clr;
    bit                  en;
    bit                  busy;
    bit                  done;
    bit                  chk_cur;
    bit                  abortable;
    logic [7:0]          sel;
    logic [1:0]          bc;
    logic [7:0]          gcnt;
    logic [N-1:0]        seed;
    logic [1:0][N-1:0]   cur;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic [N-1:0] seed;
  logic [7:0]   gens;

  logic [N-1:0]  cur [2];
  logic [N-1:0]  ld_data [2];
  logic          ld [2], clr [2], en [2], bc [2], busy [2], done [2];
  logic [IW-1:0] bsel [2];
  logic [7:0]    gcnt [2];

  int   n_checks = 0;
  int   n_pass   = 0;
  int   busy_cnt, en_cnt, done_cnt, clr_cnt;
  bit   chk_en = 1'b0;
  logic [7:0] gen_hold = 8'd0;
  exp_t exp_q[$];
  exp_t ce;

  always #5 clk = ~clk;

  ca_rule_sequencer #(.N(N), .RULE(8'd90)) u_dut90 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed), .gens(gens),
    .cur(cur[0]), .ld(ld[0]), .ld_data(ld_data[0]), .clr(clr[0]), .en(en[0]),
    .bitSelect(bsel[0]), .bitChange(bc[0]), .busy(busy[0]), .done(done[0]), .gen_cnt(gcnt[0]));

  ca_rule_sequencer #(.N(N), .RULE(8'd204)) u_dut204 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed), .gens(gens),
    .cur(cur[1]), .ld(ld[1]), .ld_data(ld_data[1]), .clr(clr[1]), .en(en[1]),
    .bitSelect(bsel[1]), .bitChange(bc[1]), .busy(busy[1]), .done(done[1]), .gen_cnt(gcnt[1]));

  // Bit-changer register models: clear, load, or single-bit write.
  always @(posedge clk or posedge rst) begin
    for (int j = 0; j < 2; j++) begin
      if (rst)         cur[j] <= '0;
      else if (clr[j]) cur[j] <= '0;
      else if (ld[j])  cur[j] <= ld_data[j];
      else if (en[j])  cur[j][bsel[j]] <= bc[j];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [N-1:0] next_gen(input logic [N-1:0] w, input logic [7:0] rule);
    logic [N-1:0] nw;
    logic l, c, r;
    nw = '0;
    for (int i = 0; i < N; i++) begin
      l = w[(i + 1) % N];
      c = w[i];
      r = w[(i + N - 1) % N];
`ifdef CA_NULL_BOUNDARY_EN
      if (i == N - 1) l = 1'b0;
      if (i == 0)     r = 1'b0;
`endif
      nw[i] = rule[{l, c, r}];
    end
    return nw;
  endfunction

  function automatic exp_t idle_e(input logic [7:0] g);
    exp_t e;
    e      = '0;
    e.gcnt = g;
    return e;
  endfunction

  // One compare process: every cycle, each DUT against the predicted trace (idle when none pending).
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() > 0) ce = exp_q.pop_front();
      else                  ce = idle_e(gen_hold);
      for (int j = 0; j < 2; j++) begin
        check($sformatf("dut%0d.ld", j),      32'(ld[j]),   32'(ce.ld));
        check($sformatf("dut%0d.clr", j),     32'(clr[j]),  32'(ce.clr));
        check($sformatf("dut%0d.en", j),      32'(en[j]),   32'(ce.en));
        check($sformatf("dut%0d.busy", j),    32'(busy[j]), 32'(ce.busy));
        check($sformatf("dut%0d.done", j),    32'(done[j]), 32'(ce.done));
        check($sformatf("dut%0d.gen_cnt", j), 32'(gcnt[j]), 32'(ce.gcnt));
        if (ce.ld) check($sformatf("dut%0d.ld_data", j), 32'(ld_data[j]), 32'(ce.seed));
        if (ce.en) begin
          check($sformatf("dut%0d.bitSelect", j), 32'(bsel[j]), 32'(ce.sel));
          check($sformatf("dut%0d.bitChange", j), 32'(bc[j]),   32'(ce.bc[j]));
        end
        if (ce.chk_cur) check($sformatf("dut%0d.cur", j), 32'(cur[j]), 32'(ce.cur[j]));
      end
      busy_cnt += int'(busy[0]);
      en_cnt   += int'(en[0]);
      done_cnt += int'(done[0]);
      clr_cnt  += int'(clr[0]);
    end
  end

  // Start a run, predict its full trace from the generation rule, and drive it to completion.
  // abort_at / glitch_at are trace positions (0 = the start cycle) where abort / start are held high.
  task automatic run(input logic [N-1:0] s, input logic [7:0] g, input int abort_at, input int glitch_at);
    exp_t tr[$];
    exp_t e;
    logic [N-1:0] w90, w204, n90, n204;
    logic [7:0] gh;
    @(posedge clk); #1;
    seed  = s;
    gens  = g;
    start = 1'b1;
    abort = (abort_at == 0);
    busy_cnt = 0; en_cnt = 0; done_cnt = 0; clr_cnt = 0;

    tr.push_back(idle_e(gen_hold));
    e = '0; e.ld = 1; e.busy = 1; e.abortable = 1; e.seed = s;
    tr.push_back(e);
    w90 = s; w204 = s;
    for (int gi = 0; gi < int'(g); gi++) begin
      e = '0; e.busy = 1; e.abortable = 1; e.gcnt = 8'(gi);
      tr.push_back(e);
      n90  = next_gen(w90, 8'd90);
      n204 = next_gen(w204, 8'd204);
      for (int i = 0; i < N; i++) begin
        e = '0; e.en = 1; e.busy = 1; e.abortable = 1; e.gcnt = 8'(gi);
        e.sel = 8'(i); e.bc = {n204[i], n90[i]};
        tr.push_back(e);
      end
      w90 = n90; w204 = n204;
    end
    e = '0; e.busy = 1; e.done = 1; e.gcnt = g; e.chk_cur = 1; e.cur = {w204, w90};
    tr.push_back(e);
    gh = g;

    if (abort_at >= 0 && abort_at < tr.size() && tr[abort_at].abortable) begin
      gh = tr[abort_at].gcnt;
      while (tr.size() > abort_at + 1) void'(tr.pop_back());
      e = idle_e(gh); e.clr = 1;
      tr.push_back(e);
      e = idle_e(gh); e.chk_cur = 1; e.cur = '0;
      tr.push_back(e);
    end
    gen_hold = gh;
    foreach (tr[k]) exp_q.push_back(tr[k]);

    for (int k = 1; k < tr.size() + 3; k++) begin
      @(posedge clk); #1;
      start = (k == glitch_at);
      abort = (k == abort_at);
    end
    start = 1'b0;
    abort = 1'b0;
    check("trace_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [N-1:0] rs;
    rst = 1'b1; start = 1'b0; abort = 1'b0; seed = '0; gens = 8'd0;
    repeat (2) @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      check("reset.ld",        32'(ld[j]),      32'd0);
      check("reset.clr",       32'(clr[j]),     32'd0);
      check("reset.en",        32'(en[j]),      32'd0);
      check("reset.bitSelect", 32'(bsel[j]),    32'd0);
      check("reset.bitChange", 32'(bc[j]),      32'd0);
      check("reset.busy",      32'(busy[j]),    32'd0);
      check("reset.done",      32'(done[j]),    32'd0);
      check("reset.gen_cnt",   32'(gcnt[j]),    32'd0);
      check("reset.ld_data",   32'(ld_data[j]), 32'd0);
    end
    @(posedge clk); #1;
    rst    = 1'b0;
    chk_en = 1'b1;

    // Single generation of rule 90 from a lone set bit.
    run(25'h0000001, 8'd1, -1, -1);
    check("g1.cur",  32'(cur[0]), 32'(EXP_G1));
    check("g1.busy", 32'(busy_cnt), 32'd28);
    check("g1.en",   32'(en_cnt), 32'd25);
    check("g1.done", 32'(done_cnt), 32'd1);

    // Two generations, with a stray start during SCAN that must be ignored.
    run(25'h0000001, 8'd2, -1, 10);
    check("g2.cur",     32'(cur[0]), 32'(EXP_G2));
    check("g2.gen_cnt", 32'(gcnt[0]), 32'd2);
    check("g2.busy",    32'(busy_cnt), 32'd54);

    // Zero generations: load then done.
    run(25'h1ABCDEF, 8'd0, -1, -1);
    check("g0.cur",  32'(cur[0]), 32'h1ABCDEF);
    check("g0.busy", 32'(busy_cnt), 32'd2);
    check("g0.en",   32'(en_cnt), 32'd0);

    // Rule 204 is the identity.
    rs = N'($urandom);
    run(rs, 8'd3, -1, -1);
    check("id.cur",  32'(cur[1]), 32'(rs));
    check("id.busy", 32'(busy_cnt), 32'd80);

    // Abort at the 10th SCAN cycle of generation 1 (trace slot 12), then a clean rerun.
    run(25'h0000001, 8'd1, 12, -1);
    check("abort.clr",  32'(clr_cnt), 32'd1);
    check("abort.done", 32'(done_cnt), 32'd0);
    check("abort.busy", 32'(busy_cnt), 32'd12);
    check("abort.cur",  32'(cur[0]), 32'd0);
    run(25'h0000001, 8'd1, -1, -1);
    check("rerun.cur", 32'(cur[0]), 32'(EXP_G1));

    // start and abort together in IDLE: start wins.
    run(25'h0000001, 8'd1, 0, -1);
    check("st_ab.done", 32'(done_cnt), 32'd1);
    check("st_ab.cur",  32'(cur[0]), 32'(EXP_G1));

    // abort in DONE is ignored.
    run(25'h0000001, 8'd1, 28, -1);
    check("ab_done.done", 32'(done_cnt), 32'd1);
    check("ab_done.clr",  32'(clr_cnt), 32'd0);

    // Maximum generation count.
    rs = N'($urandom);
    run(rs, 8'd255, -1, -1);
    check("g255.gen_cnt", 32'(gcnt[0]), 32'd255);
    check("g255.id",      32'(cur[1]), 32'(rs));

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
